// File: rtl/serial_addsub.sv
// Bit-serial LSB-first adder/subtractor: one full-add/full-sub bit cell reused for WIDTH cycles.
// Latency: start accepted at edge k, result/cout/ovf update and done pulses after edge k+WIDTH.
// Backpressure: none; start is only sampled in IDLE and is ignored while busy (RUN or DONE).
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   start, op, a, b   request strobe, 0=add 1=sub, operands (captured together in IDLE)
//   busy, done        busy in RUN/DONE; one-cycle done pulse with a valid result
//   result, cout, ovf registered sum/difference, carry-or-borrow out, signed overflow
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    // WIDTH-1 fits in clog2(WIDTH) bits, so the counter never wraps inside RUN.
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             op_r;
    logic             c_r;
    logic [CW-1:0]    cnt;

    logic             ai;
    logic             bi;
    logic             s;
    logic             c_next;
    logic             last_bit;

    // Bit cell plus next-state logic.
    always_comb begin
        ai        = a_sh[0];
        bi        = b_sh[0];
        s         = ai ^ bi ^ c_r;
        c_next    = 1'b0;
        if (op_r) begin
            c_next = (~ai & bi) | (~(ai ^ bi) & c_r);
        end else begin
            c_next = (ai & bi) | (ai & c_r) | (bi & c_r);
        end
        last_bit  = (cnt == CW'(WIDTH - 1));

        state_nxt = state;
        case (state)
            IDLE:    if (start)    state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:                  state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            op_r   <= 1'b0;
            c_r    <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            // busy tracks the state being entered so it is high exactly in RUN and DONE.
            busy <= (state_nxt != IDLE);
            done <= (state == RUN) && last_bit;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= a;
                        b_sh <= b;
                        op_r <= op;
                        c_r  <= 1'b0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= {s, res_sh[WIDTH-1:1]};
                    c_r    <= c_next;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        result <= {s, res_sh[WIDTH-1:1]};
                        cout   <= c_next;
                        // Signed overflow: carry/borrow into the MSB differs from the one out of it.
                        ovf    <= c_r ^ c_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    int n_assert;
    int n_fail;

    serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent reference: plain integer arithmetic on 8-bit operands.
    task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic mop,
                         output logic [7:0] mres, output logic mc, output logic mv);
        logic [8:0] full;
        if (mop == 1'b0) begin
            full = {1'b0, ma} + {1'b0, mb};
            mres = full[7:0];
            mc   = full[8];
            mv   = (ma[7] == mb[7]) && (mres[7] != ma[7]);
        end else begin
            mres = ma - mb;
            mc   = (ma < mb);
            mv   = (ma[7] != mb[7]) && (mres[7] != ma[7]);
        end
    endtask

    // One operation from IDLE; edges counts posedges from the accepting one until done is seen.
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                          input logic top, input logic [7:0] eres, input logic ec, input logic ev);
        int edges;
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_; op = top;
        @(negedge clk);
        start = 1'b0;
        edges = 1;
        while (done !== 1'b1 && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        chk({tag, " latency"}, edges, WIDTH + 1);
        chk({tag, " result"}, result, eres);
        chk({tag, " cout"}, cout, ec);
        chk({tag, " ovf"}, ovf, ev);
        chk({tag, " busy in done"}, busy, 1);
        @(negedge clk);
        chk({tag, " done pulse width"}, done, 0);
        chk({tag, " busy after"}, busy, 0);
    endtask

    logic [7:0] ra [16];
    logic [7:0] rb [16];
    logic       rop[16];
    logic [7:0] m_res;
    logic       m_c;
    logic       m_v;
    int         done_cnt;

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset result", result, 0);
        chk("reset cout", cout, 0);
        chk("reset ovf", ovf, 0);
        rst = 1'b0;

        run_op("add 100+55", 8'd100, 8'd55, 1'b0, 8'h9B, 1'b0, 1'b1);
        run_op("add 200+100", 8'd200, 8'd100, 1'b0, 8'h2C, 1'b1, 1'b0);
        run_op("sub 5-3", 8'd5, 8'd3, 1'b1, 8'h02, 1'b0, 1'b0);
        run_op("sub 3-5", 8'd3, 8'd5, 1'b1, 8'hFE, 1'b1, 1'b0);
        run_op("sub 80-01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1);

        // Starts during RUN must not disturb the run in progress.
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1; a = 8'h10; b = 8'h20; op = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            start = (i == 3 || i == 5);
            a = 8'hE7; b = 8'h5A; op = 1'b1;
            if (done === 1'b1) done_cnt++;
            if (i == 8) chk("ignore busy mid-run", busy, 1);
            if (i == 9) begin
                chk("ignore done", done, 1);
                chk("ignore busy in done", busy, 1);
                chk("ignore result", result, 8'h30);
                chk("ignore cout", cout, 0);
                chk("ignore ovf", ovf, 0);
            end
            if (i == 10) chk("ignore busy idle", busy, 0);
        end
        start = 1'b0;
        chk("ignore done count", done_cnt, 1);
        chk("ignore result held", result, 8'h30);

        // Abort mid-RUN with reset.
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1; a = 8'hFF; b = 8'h01; op = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort result", result, 0);
        chk("abort cout", cout, 0);
        chk("abort ovf", ovf, 0);
        repeat (2) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        chk("abort no done", done_cnt, 0);
        chk("abort stays idle", busy, 0);
        run_op("add FF+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);

        // start held high: accepts at edges 1, 11, 21, ...; done seen after edges 9, 19, 29, ...
        @(negedge clk);
        ra[1] = 8'($urandom); rb[1] = 8'($urandom); rop[1] = 1'($urandom);
        start = 1'b1; a = ra[1]; b = rb[1]; op = rop[1];
        for (int e = 1; e <= 2000; e++) begin
            @(negedge clk);
            chk("stream done timing", done, (e % 10) == 9);
            if ((e % 10) == 9) begin
                model(ra[(e - 8) % 16], rb[(e - 8) % 16], rop[(e - 8) % 16], m_res, m_c, m_v);
                chk("stream result", result, m_res);
                chk("stream cout", cout, m_c);
                chk("stream ovf", ovf, m_v);
            end
            ra[(e + 1) % 16]  = 8'($urandom);
            rb[(e + 1) % 16]  = 8'($urandom);
            rop[(e + 1) % 16] = 1'($urandom);
            a  = ra[(e + 1) % 16];
            b  = rb[(e + 1) % 16];
            op = rop[(e + 1) % 16];
        end
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("final idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
